rgb_to_hsv_unit: RTL and testbench



---
 rtl/rgb_to_hsv_unit.sv | 170 +++++++++++++++++
 tb/tb_rgb_to_hsv_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rgb_to_hsv_unit.sv
// RGB332 to quantised HSV (h 0..11, s/v 0..7) through one shared restoring divider.
// Optional macro RGB2HSV_BYPASS_GRAY_EN lets grey colours skip both divisions.
module rgb_to_hsv_unit #(
  parameter logic B_LSB_FILL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] color,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] h,
  output logic [2:0] s,
  output logic [2:0] v,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, PREP, DIV_H, DIV_S, FIN, DONE} state_t;

  state_t     state;
  logic [7:0] col;
  logic [9:0] num;
  logic [3:0] den;
  logic [3:0] rem;
  logic [9:0] quot;
  logic [3:0] cnt;
  logic [5:0] hq;

  logic [2:0] r, g, b3, mx, mn, d, base, x, y;
  logic [9:0] base_w, d_w, x_w, y_w, hnum;
  logic [5:0] d6, snum;
  logic [4:0] trial;
  logic [3:0] diff, rem_nxt;
  logic       ge;
  logic [9:0] quot_nxt;
  logic [5:0] hmod;

  assign r  = col[7:5];
  assign g  = col[4:2];
  assign b3 = {col[1:0], B_LSB_FILL};

  always_comb begin
    mx = r;
    if (g > mx) mx = g;
    if (b3 > mx) mx = b3;
    mn = r;
    if (g < mn) mn = g;
    if (b3 < mn) mn = b3;
    d = mx - mn;
    // Primary channel priority r > g > b on ties
    if (r == mx) begin
      base = 3'd0; x = g;  y = b3;
    end else if (g == mx) begin
      base = 3'd2; x = b3; y = r;
    end else begin
      base = 3'd4; x = r;  y = g;
    end
  end

  // Hue numerator is offset by 24 sectors (48*d) so it never goes negative;
  // the extra +d rounds to the nearest 30-degree sector.
  assign base_w = {7'b0, base};
  assign d_w    = {7'b0, d};
  assign x_w    = {7'b0, x};
  assign y_w    = {7'b0, y};
  assign hnum   = ((base_w * d_w) << 2) + (x_w << 2) - (y_w << 2) + d_w * 10'd49;
  assign d6     = {3'b0, d};
  assign snum   = d6 * 6'd7;

  // One restoring-division step; remainder always fits 4 bits when den != 0.
  assign trial    = {rem, num[9]};
  assign ge       = trial >= {1'b0, den};
  assign diff     = trial[3:0] - den;
  assign rem_nxt  = ge ? diff : trial[3:0];
  assign quot_nxt = {quot[8:0], ge};

  always_comb begin
    hmod = hq;
    if (hmod >= 6'd12) hmod = hmod - 6'd12;
    if (hmod >= 6'd12) hmod = hmod - 6'd12;
    if (hmod >= 6'd12) hmod = hmod - 6'd12;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      num       <= '0;
      den       <= '0;
      rem       <= '0;
      quot      <= '0;
      cnt       <= '0;
      hq        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      h         <= '0;
      s         <= '0;
      v         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            col      <= color;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          num   <= hnum;
          den   <= {d, 1'b0};
          rem   <= '0;
          quot  <= '0;
          cnt   <= '0;
          state <= DIV_H;
`ifdef RGB2HSV_BYPASS_GRAY_EN
          if (d == 3'd0) state <= FIN;
`endif
        end
        DIV_H: begin
          num  <= num << 1;
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            hq    <= quot_nxt[5:0];
            num   <= {snum, 4'b0};
            den   <= {1'b0, mx};
            rem   <= '0;
            quot  <= '0;
            cnt   <= '0;
            state <= DIV_S;
          end
        end
        DIV_S: begin
          num  <= num << 1;
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd5) state <= FIN;
        end
        FIN: begin
          v <= mx;
          if (d == 3'd0) begin
            h <= 4'd0;
            s <= 3'd0;
          end else begin
            h <= hmod[3:0];
            s <= quot[2:0];
          end
          state <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_hsv_unit.sv
// Directed self-checking bench for rgb_to_hsv_unit (honours RGB2HSV_BYPASS_GRAY_EN for grey latency).
module tb_rgb_to_hsv_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] color;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] h;
  logic [2:0] s;
  logic [2:0] v;
  logic       busy;

  int errors = 0;
  int checks = 0;

  rgb_to_hsv_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .color(color), .out_valid(out_valid), .out_ready(out_ready),
    .h(h), .s(s), .v(v), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a colour and let it be accepted; returns #1 after the accept edge.
  task automatic start(input logic [7:0] c, input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    color    = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    color    = 8'h00;
  endtask

  // Count edges from the accept edge to out_valid, then check latency and result.
  task automatic wait_out(input int elat, input int eh, input int es, input int ev,
                          input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 60);
    chk({tag, "_latency"}, n, elat);
    chk({tag, "_h"}, int'(h), eh);
    chk({tag, "_s"}, int'(s), es);
    chk({tag, "_v"}, int'(v), ev);
  endtask

  task automatic finish_hs(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_ov_fall"}, int'(out_valid), 0);
    chk({tag, "_ir_rise"}, int'(in_ready), 1);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int n;
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    chk({tag, "_no_out_valid"}, n, 0);
  endtask

  initial begin
    int gl;
    int unstable;
    logic [3:0] h0;
    logic [2:0] s0, v0;
`ifdef RGB2HSV_BYPASS_GRAY_EN
    gl = 3;
`else
    gl = 19;
`endif
    rst_n = 1'b0; in_valid = 1'b1; color = 8'hE0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_h", int'(h), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_v", int'(v), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    quiet(25, "post_rst");

    // Primaries
    start(8'hE0, "red");    wait_out(19, 0, 7, 7, "red");    finish_hs("red");
    start(8'h1C, "green");  wait_out(19, 4, 7, 7, "green");  finish_hs("green");
    start(8'h03, "blue");   wait_out(19, 8, 7, 6, "blue");   finish_hs("blue");
    start(8'hFC, "yellow"); wait_out(19, 2, 7, 7, "yellow"); finish_hs("yellow");

    // Mixed colours: r4 g2 b01, r7 g3 b00
    start(8'h89, "mix1");   wait_out(19, 0, 3, 4, "mix1");   finish_hs("mix1");
    start(8'hEC, "mix2");   wait_out(19, 1, 7, 7, "mix2");   finish_hs("mix2");

    // Grey r6 g6 b11
    start(8'hDB, "grey");   wait_out(gl, 0, 0, 6, "grey");   finish_hs("grey");

    // Back-pressure with a new request held during DONE
    out_ready = 1'b0;
    start(8'h1C, "bp");
    wait_out(19, 4, 7, 7, "bp");
    @(negedge clk);
    in_valid = 1'b1;
    color    = 8'hE0;
    h0 = h; s0 = s; v0 = v;
    unstable = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || h !== h0 || s !== s0 || v !== v0) unstable++;
    end
    chk("bp_hold_stable", unstable, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ov_fall", int'(out_valid), 0);
    chk("bp_ir_rise", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accept_ir", int'(in_ready), 0);
    chk("bp_next_accept_busy", int'(busy), 1);
    wait_out(19, 0, 7, 7, "bp_next");
    finish_hs("bp_next");

    // Reset in the middle of the hue division
    start(8'h1C, "abort");
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet(25, "abort");
    start(8'hE0, "after_abort");
    wait_out(19, 0, 7, 7, "after_abort");
    finish_hs("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
